// File: rtl/frame_receiver.sv
// ---------------------------------------------------------------------------
// frame_receiver
//   Receive-side deframer. Hunts the 2-byte frame alignment signal (FAS0,
//   FAS1) in the incoming line byte stream, collects PYLD_LEN payload bytes
//   into an internal buffer while running a CRC-8 (poly 0x07, init 0x00,
//   MSB-first), then checks the trailing CRC byte. With ARQ enabled it
//   returns ACK/NAK and only releases the payload on a pass; with ARQ
//   disabled the payload is always released and no response is sent.
//
// Ports
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_line_data / _valid, o_line_data_ready   line bytes from the RX FIFO
//   o_pyld_data / _valid, i_pyld_data_ready   payload bytes to the client
//   o_resp_data / _valid, i_resp_data_ready   ACK/NAK byte to response TX
//   i_arq_en                           ARQ mode, latched at the FAS1 match
//   o_crc_val                          CRC computed over the last frame
//   o_good_cnt, o_bad_cnt              saturating CRC pass / fail counters
//   o_rx_state                         FSM state encoding
// ---------------------------------------------------------------------------
module frame_receiver #(
   parameter logic [7:0]  FAS0     = 8'hF6,
   parameter logic [7:0]  FAS1     = 8'h28,
   parameter int unsigned PYLD_LEN = 16,
   parameter logic [7:0]  ACK_BYTE = 8'hAA,
   parameter logic [7:0]  NAK_BYTE = 8'h55
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_line_data,
   input  logic       i_line_data_valid,
   output logic       o_line_data_ready,
   output logic [7:0] o_pyld_data,
   output logic       o_pyld_data_valid,
   input  logic       i_pyld_data_ready,
   output logic [7:0] o_resp_data,
   output logic       o_resp_data_valid,
   input  logic       i_resp_data_ready,
   input  logic       i_arq_en,
   output logic [7:0] o_crc_val,
   output logic [7:0] o_good_cnt,
   output logic [7:0] o_bad_cnt,
   output logic [2:0] o_rx_state
);

   localparam int unsigned AW       = (PYLD_LEN > 1) ? $clog2(PYLD_LEN) : 1;
   localparam logic [7:0]  LAST_IDX = 8'(PYLD_LEN - 1);

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_FAS   = 3'd1,
      ST_PYLD  = 3'd2,
      ST_CRC   = 3'd3,
      ST_RESP  = 3'd4,
      ST_DRAIN = 3'd5
   } state_e;

   state_e     state_q,      state_d;
   logic       arq_q,        arq_d;
   logic       pass_q,       pass_d;
   logic [7:0] crc_q,        crc_d;
   logic [7:0] crc_val_q,    crc_val_d;
   logic [7:0] good_q,       good_d;
   logic [7:0] bad_q,        bad_d;
   logic [7:0] wr_ptr_q,     wr_ptr_d;
   logic [7:0] rd_ptr_q,     rd_ptr_d;
   logic [7:0] pyld_data_q,  pyld_data_d;
   logic       pyld_valid_q, pyld_valid_d;
   logic [7:0] resp_data_q,  resp_data_d;
   logic       resp_valid_q, resp_valid_d;

   logic [7:0]    buf_mem [PYLD_LEN];
   logic          buf_we;
   logic [AW-1:0] buf_waddr;
   logic [7:0]    buf_wdata;

   logic       line_ready;
   logic       line_acc;
   logic       crc_pass;
   logic [7:0] crc_upd;
   logic [7:0] rd_next;

   // One byte of CRC-8, poly 0x07, MSB-first, no reflection.
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   // The line is backpressured while a response or payload is outstanding,
   // and also during the reset cycle itself.
   assign line_ready = i_rst_n && (state_q == ST_HUNT || state_q == ST_FAS ||
                                   state_q == ST_PYLD || state_q == ST_CRC);
   assign line_acc   = i_line_data_valid && line_ready;
   assign crc_pass   = (i_line_data == crc_q);
   assign crc_upd    = crc8_next(crc_q, i_line_data);
   assign rd_next    = rd_ptr_q + 8'd1;

   always_comb begin
      // NOTE: every signal driven here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d      = state_q;
      arq_d        = arq_q;
      pass_d       = pass_q;
      crc_d        = crc_q;
      crc_val_d    = crc_val_q;
      good_d       = good_q;
      bad_d        = bad_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      pyld_data_d  = pyld_data_q;
      pyld_valid_d = pyld_valid_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = resp_valid_q;
      buf_we       = 1'b0;
      buf_waddr    = wr_ptr_q[AW-1:0];
      buf_wdata    = i_line_data;

      unique case (state_q)
         ST_HUNT: begin
            if (line_acc && i_line_data == FAS0) state_d = ST_FAS;
         end

         ST_FAS: begin
            if (line_acc) begin
               if (i_line_data == FAS1) begin
                  arq_d    = i_arq_en;
                  crc_d    = 8'h00;
                  wr_ptr_d = 8'h00;
                  rd_ptr_d = 8'h00;
                  state_d  = ST_PYLD;
               end else if (i_line_data != FAS0) begin
                  // A repeated FAS0 keeps the hunt armed; anything else drops it.
                  state_d = ST_HUNT;
               end
            end
         end

         ST_PYLD: begin
            if (line_acc) begin
               buf_we   = 1'b1;
               crc_d    = crc_upd;
               wr_ptr_d = wr_ptr_q + 8'd1;
               if (wr_ptr_q == LAST_IDX) state_d = ST_CRC;
            end
         end

         ST_CRC: begin
            if (line_acc) begin
               pass_d    = crc_pass;
               crc_val_d = crc_q;
               if (crc_pass) begin
                  if (good_q != 8'hFF) good_d = good_q + 8'd1;
               end else begin
                  if (bad_q != 8'hFF) bad_d = bad_q + 8'd1;
               end
               if (arq_q) begin
                  resp_data_d  = crc_pass ? ACK_BYTE : NAK_BYTE;
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end

         ST_RESP: begin
            if (i_resp_data_ready) begin
               resp_valid_d = 1'b0;
               // A failed frame is dropped: its buffer is simply never read.
               state_d      = pass_q ? ST_DRAIN : ST_HUNT;
            end
         end

         ST_DRAIN: begin
            if (!pyld_valid_q) begin
               // First DRAIN cycle primes the registered output.
               pyld_data_d  = buf_mem[rd_ptr_q[AW-1:0]];
               pyld_valid_d = 1'b1;
            end else if (i_pyld_data_ready) begin
               rd_ptr_d = rd_next;
               if (rd_ptr_q == LAST_IDX) begin
                  pyld_valid_d = 1'b0;
                  state_d      = ST_HUNT;
               end else begin
                  pyld_data_d = buf_mem[rd_next[AW-1:0]];
               end
            end
         end

         default: state_d = ST_HUNT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!i_rst_n) begin
         state_q      <= ST_HUNT;
         arq_q        <= 1'b0;
         pass_q       <= 1'b0;
         crc_q        <= 8'h00;
         crc_val_q    <= 8'h00;
         good_q       <= 8'h00;
         bad_q        <= 8'h00;
         wr_ptr_q     <= 8'h00;
         rd_ptr_q     <= 8'h00;
         pyld_data_q  <= 8'h00;
         pyld_valid_q <= 1'b0;
         resp_data_q  <= 8'h00;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         arq_q        <= arq_d;
         pass_q       <= pass_d;
         crc_q        <= crc_d;
         crc_val_q    <= crc_val_d;
         good_q       <= good_d;
         bad_q        <= bad_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pyld_data_q  <= pyld_data_d;
         pyld_valid_q <= pyld_valid_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   // NOTE: the payload buffer has no reset; every entry is written before it
   // is read within a frame, so the pointers alone define its contents.
   always_ff @(posedge i_clk) begin
      if (buf_we) buf_mem[buf_waddr] <= buf_wdata;
   end

   assign o_line_data_ready = line_ready;
   assign o_pyld_data       = pyld_data_q;
   assign o_pyld_data_valid = pyld_valid_q;
   assign o_resp_data       = resp_data_q;
   assign o_resp_data_valid = resp_valid_q;
   assign o_crc_val         = crc_val_q;
   assign o_good_cnt        = good_q;
   assign o_bad_cnt         = bad_q;
   assign o_rx_state        = state_q;

endmodule

// File: tb/tb_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_frame_receiver
//   Drives line bytes and client/response ready signals, keeps a frame-level
//   reference model (byte queue + whole-message polynomial division for the
//   CRC) and compares every DUT output against it on each negative edge.
//   Directed scenarios add literal expectations for the known frames.
// ---------------------------------------------------------------------------
module tb_frame_receiver;

   localparam int         LEN = 9;
   localparam logic [7:0] F0  = 8'hF6;
   localparam logic [7:0] F1  = 8'h28;
   localparam logic [7:0] ACK = 8'hAA;
   localparam logic [7:0] NAK = 8'h55;

   localparam int PH_HUNT = 0, PH_FAS = 1, PH_PYLD = 2, PH_CRC = 3, PH_RESP = 4, PH_DRAIN = 5;

   logic       clk;
   logic       rst_n;
   logic [7:0] i_line_data;
   logic       i_line_data_valid;
   logic       o_line_data_ready;
   logic [7:0] o_pyld_data;
   logic       o_pyld_data_valid;
   logic       i_pyld_data_ready;
   logic [7:0] o_resp_data;
   logic       o_resp_data_valid;
   logic       i_resp_data_ready;
   logic       i_arq_en;
   logic [7:0] o_crc_val;
   logic [7:0] o_good_cnt;
   logic [7:0] o_bad_cnt;
   logic [2:0] o_rx_state;

   frame_receiver #(
      .FAS0(F0), .FAS1(F1), .PYLD_LEN(LEN), .ACK_BYTE(ACK), .NAK_BYTE(NAK)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_line_data       (i_line_data),
      .i_line_data_valid (i_line_data_valid),
      .o_line_data_ready (o_line_data_ready),
      .o_pyld_data       (o_pyld_data),
      .o_pyld_data_valid (o_pyld_data_valid),
      .i_pyld_data_ready (i_pyld_data_ready),
      .o_resp_data       (o_resp_data),
      .o_resp_data_valid (o_resp_data_valid),
      .i_resp_data_ready (i_resp_data_ready),
      .i_arq_en          (i_arq_en),
      .o_crc_val         (o_crc_val),
      .o_good_cnt        (o_good_cnt),
      .o_bad_cnt         (o_bad_cnt),
      .o_rx_state        (o_rx_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // CRC by long division of the message, augmented with 8 zero bits, by 0x107.
   function automatic logic [7:0] ref_crc(input logic [7:0] msg [$]);
      logic [8:0] r;
      logic [7:0] b;
      r = 9'h000;
      for (int i = 0; i <= msg.size(); i++) begin
         b = (i < msg.size()) ? msg[i] : 8'h00;
         for (int k = 7; k >= 0; k--) begin
            r = {r[7:0], b[k]};
            if (r[8]) r = r ^ 9'h107;
         end
      end
      return r[7:0];
   endfunction

   // ---------------- reference model state ----------------
   int         m_phase = PH_HUNT;
   bit         m_arq, m_pass, m_first;
   int         m_idx;
   logic [7:0] m_q [$];
   logic [7:0] m_good = 8'h00, m_bad = 8'h00, m_crc = 8'h00;

   bit         armed = 1'b0;
   logic [7:0] resp_log [$];
   logic [7:0] pyld_log [$];
   int         resp_stalls, pyld_stalls;
   bit         prev_p_hold, prev_r_hold;
   logic [7:0] prev_p_data, prev_r_data;

   // Compare then advance the model, once per cycle on the falling edge.
   initial begin
      bit exp_ready, exp_pv, acc;
      forever begin
         @(negedge clk);
         exp_ready = rst_n && (m_phase <= PH_CRC);
         exp_pv    = (m_phase == PH_DRAIN) && !m_first;
         if (armed) begin
            check("rx_state",   32'(o_rx_state), 32'(m_phase));
            check("line_ready", 32'(o_line_data_ready), 32'(exp_ready));
            check("resp_valid", 32'(o_resp_data_valid), 32'(m_phase == PH_RESP));
            if (m_phase == PH_RESP)
               check("resp_data", 32'(o_resp_data), 32'(m_pass ? ACK : NAK));
            check("pyld_valid", 32'(o_pyld_data_valid), 32'(exp_pv));
            if (exp_pv && m_idx < m_q.size())
               check("pyld_data", 32'(o_pyld_data), 32'(m_q[m_idx]));
            check("good_cnt", 32'(o_good_cnt), 32'(m_good));
            check("bad_cnt",  32'(o_bad_cnt),  32'(m_bad));
            check("crc_val",  32'(o_crc_val),  32'(m_crc));
            if (prev_p_hold)
               check("pyld_stable", 32'({o_pyld_data_valid, o_pyld_data}), 32'({1'b1, prev_p_data}));
            if (prev_r_hold)
               check("resp_stable", 32'({o_resp_data_valid, o_resp_data}), 32'({1'b1, prev_r_data}));
            if (rst_n && o_resp_data_valid && i_resp_data_ready) resp_log.push_back(o_resp_data);
            if (rst_n && o_pyld_data_valid && i_pyld_data_ready) pyld_log.push_back(o_pyld_data);
            if (o_resp_data_valid && !i_resp_data_ready) resp_stalls++;
            if (o_pyld_data_valid && !i_pyld_data_ready) pyld_stalls++;
         end
         prev_p_hold = rst_n && o_pyld_data_valid && !i_pyld_data_ready;
         prev_r_hold = rst_n && o_resp_data_valid && !i_resp_data_ready;
         prev_p_data = o_pyld_data;
         prev_r_data = o_resp_data;

         if (!rst_n) begin
            m_phase = PH_HUNT;
            m_good  = 8'h00;
            m_bad   = 8'h00;
            m_crc   = 8'h00;
            m_first = 1'b0;
            m_pass  = 1'b0;
            m_idx   = 0;
            m_q.delete();
         end else begin
            acc = i_line_data_valid && exp_ready;
            case (m_phase)
               PH_HUNT: if (acc && i_line_data == F0) m_phase = PH_FAS;
               PH_FAS: if (acc) begin
                  if (i_line_data == F1) begin
                     m_arq = i_arq_en;
                     m_q.delete();
                     m_phase = PH_PYLD;
                  end else if (i_line_data != F0) begin
                     m_phase = PH_HUNT;
                  end
               end
               PH_PYLD: if (acc) begin
                  m_q.push_back(i_line_data);
                  if (m_q.size() == LEN) m_phase = PH_CRC;
               end
               PH_CRC: if (acc) begin
                  m_crc  = ref_crc(m_q);
                  m_pass = (i_line_data == m_crc);
                  if (m_pass) begin
                     if (m_good != 8'hFF) m_good = m_good + 8'd1;
                  end else begin
                     if (m_bad != 8'hFF) m_bad = m_bad + 8'd1;
                  end
                  if (m_arq) m_phase = PH_RESP;
                  else begin
                     m_phase = PH_DRAIN; m_first = 1'b1; m_idx = 0;
                  end
               end
               PH_RESP: if (i_resp_data_ready) begin
                  if (m_pass) begin
                     m_phase = PH_DRAIN; m_first = 1'b1; m_idx = 0;
                  end else begin
                     m_phase = PH_HUNT;
                  end
               end
               PH_DRAIN: begin
                  if (m_first) m_first = 1'b0;
                  else if (i_pyld_data_ready) begin
                     m_idx++;
                     if (m_idx == LEN) m_phase = PH_HUNT;
                  end
               end
               default: m_phase = PH_HUNT;
            endcase
         end
      end
   end

   // ---------------- ready generators (drive at posedge + 2) ----------------
   bit rand_ready = 1'b0;
   int pyld_hold  = 0;
   int resp_hold  = 0;

   initial begin
      i_pyld_data_ready = 1'b1;
      i_resp_data_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (pyld_hold > 0) begin
            i_pyld_data_ready = 1'b0;
            if (o_pyld_data_valid) pyld_hold--;
         end else begin
            i_pyld_data_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (resp_hold > 0) begin
            i_resp_data_ready = 1'b0;
            if (o_resp_data_valid) resp_hold--;
         end else begin
            i_resp_data_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
   end

   // ---------------- line driver (called at posedge + 1) ----------------
   bit gap_en = 1'b0;

   task automatic send_byte(input logic [7:0] b);
      int n;
      if (gap_en && $urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
      i_line_data       = b;
      i_line_data_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (o_line_data_ready) break;
         n++;
         if (n > 300) begin
            fail_bound("line_accept");
            break;
         end
      end
      @(posedge clk);
      #1;
      i_line_data_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] p [$], input logic [7:0] crc);
      send_byte(F0);
      send_byte(F1);
      foreach (p[i]) send_byte(p[i]);
      send_byte(crc);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (m_phase == PH_HUNT) break;
         n++;
         if (n > 500) begin
            fail_bound("wait_idle");
            break;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"},      32'(o_rx_state), 0);
      check({tag, "_pyld_valid"}, 32'(o_pyld_data_valid), 0);
      check({tag, "_resp_valid"}, 32'(o_resp_data_valid), 0);
      check({tag, "_crc_val"},    32'(o_crc_val), 0);
      check({tag, "_good"},       32'(o_good_cnt), 0);
      check({tag, "_bad"},        32'(o_bad_cnt), 0);
   endtask

   task automatic do_reset();
      rst_n             = 1'b0;
      i_line_data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_line_ready", 32'(o_line_data_ready), 0);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      resp_log.delete();
      pyld_log.delete();
      resp_stalls = 0;
      pyld_stalls = 0;
   endtask

   // ---------------- main sequence ----------------
   logic [7:0] digits [$];
   logic [7:0] zeros  [$];
   logic [7:0] rp     [$];

   initial begin
      int n_good_gen;
      logic [7:0] c;
      rst_n             = 1'b0;
      i_line_data       = 8'h00;
      i_line_data_valid = 1'b0;
      i_arq_en          = 1'b1;
      for (int i = 0; i < LEN; i++) digits.push_back(8'h31 + 8'(i));
      for (int i = 0; i < LEN; i++) zeros.push_back(8'h00);

      check("ref_crc_digits", 32'(ref_crc(digits)), 32'h0000_00F4);
      check("ref_crc_zeros",  32'(ref_crc(zeros)),  32'h0000_0000);

      repeat (3) @(posedge clk);
      #1;
      armed = 1'b1;
      do_reset();

      // Good frame, ARQ on.
      i_arq_en = 1'b1;
      send_frame(digits, 8'hF4);
      wait_idle();
      check("t1_crc_val", 32'(o_crc_val), 32'h0000_00F4);
      check("t1_good",    32'(o_good_cnt), 1);
      check("t1_resp_n",  resp_log.size(), 1);
      if (resp_log.size() > 0) check("t1_resp", 32'(resp_log[0]), 32'h0000_00AA);
      check("t1_pyld_n",  pyld_log.size(), LEN);
      for (int i = 0; i < pyld_log.size() && i < LEN; i++)
         check("t1_pyld", 32'(pyld_log[i]), 32'h31 + i);

      // Bad CRC, ARQ on: NAK and the payload is dropped.
      do_reset();
      send_frame(digits, 8'h00);
      wait_idle();
      check("t2_resp_n", resp_log.size(), 1);
      if (resp_log.size() > 0) check("t2_resp", 32'(resp_log[0]), 32'h0000_0055);
      check("t2_bad",    32'(o_bad_cnt), 1);
      check("t2_good",   32'(o_good_cnt), 0);
      check("t2_pyld_n", pyld_log.size(), 0);
      check("t2_state",  32'(o_rx_state), 0);

      // Bad CRC, ARQ off: no response, payload still forwarded.
      do_reset();
      i_arq_en = 1'b0;
      send_frame(digits, 8'h00);
      wait_idle();
      check("t3_resp_n", resp_log.size(), 0);
      check("t3_bad",    32'(o_bad_cnt), 1);
      check("t3_pyld_n", pyld_log.size(), LEN);
      for (int i = 0; i < pyld_log.size() && i < LEN; i++)
         check("t3_pyld", 32'(pyld_log[i]), 32'h31 + i);

      // Alignment hunt: 00 F6 F6 28 + zero payload + CRC 00, then F6 11.
      do_reset();
      i_arq_en = 1'b1;
      send_byte(8'h00);
      send_byte(F0);
      send_frame(zeros, 8'h00);
      wait_idle();
      check("t4_resp_n", resp_log.size(), 1);
      if (resp_log.size() > 0) check("t4_resp", 32'(resp_log[0]), 32'h0000_00AA);
      check("t4_good",   32'(o_good_cnt), 1);
      send_byte(F0);
      check("t4_fas_state", 32'(o_rx_state), 1);
      send_byte(8'h11);
      check("t4_unlock_state", 32'(o_rx_state), 0);
      repeat (3) @(posedge clk);
      #1;
      check("t4_good_after", 32'(o_good_cnt), 1);
      check("t4_bad_after",  32'(o_bad_cnt), 0);
      check("t4_resp_after", resp_log.size(), 1);

      // Backpressure on both response and payload paths.
      do_reset();
      resp_hold = 3;
      send_frame(digits, 8'hF4);
      begin
         int n;
         n = 0;
         while (pyld_log.size() < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (n >= 200) fail_bound("t5_drain_start");
      end
      pyld_hold = 5;
      wait_idle();
      check("t5_resp_stalls", 32'(resp_stalls >= 3), 1);
      check("t5_pyld_stalls", 32'(pyld_stalls >= 5), 1);
      check("t5_pyld_n", pyld_log.size(), LEN);
      for (int i = 0; i < pyld_log.size() && i < LEN; i++)
         check("t5_pyld", 32'(pyld_log[i]), 32'h31 + i);

      // Randomized traffic: noise prefix, random payload, mostly-good CRC.
      do_reset();
      rand_ready = 1'b1;
      gap_en     = 1'b1;
      n_good_gen = 0;
      for (int f = 0; f < 40; f++) begin
         i_arq_en = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) begin
            c = 8'($urandom_range(0, 255));
            if (c == F0) c = 8'h00;
            send_byte(c);
         end
         rp.delete();
         for (int i = 0; i < LEN; i++) rp.push_back(8'($urandom_range(0, 255)));
         c = ref_crc(rp);
         if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
         else n_good_gen++;
         send_frame(rp, c);
      end
      wait_idle();
      check("t6_good_total", 32'(o_good_cnt), n_good_gen);
      check("t6_bad_total",  32'(o_bad_cnt), 40 - n_good_gen);
      rand_ready = 1'b0;
      gap_en     = 1'b0;

      // Counter saturation, then reset during the payload.
      do_reset();
      i_arq_en = 1'b1;
      for (int f = 0; f < 256; f++) send_frame(digits, 8'hF4);
      wait_idle();
      check("t7_good_sat", 32'(o_good_cnt), 32'h0000_00FF);
      check("t7_bad",      32'(o_bad_cnt), 0);
      send_byte(F0);
      send_byte(F1);
      for (int i = 0; i < 5; i++) send_byte(digits[i]);
      check("t7_mid_state", 32'(o_rx_state), 2);
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      check_reset_outputs("t7_post");
      check("t7_resp_n", resp_log.size(), 0);
      check("t7_pyld_n", pyld_log.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
- Receive-side counterpart of the sender's mapper/transmit path.
- Takes deserialized line bytes from the line UART RX FIFO and hunts for the 2-byte frame alignment signal (FAS).
- Collects a fixed-length payload plus CRC-8 and buffers the payload internally. When ARQ is enabled, it releases the payload to the client only after the CRC passes.
- Returns a one-byte ACK or NAK toward the sender's i_otn_tx_ack path through a byte-wide handshake to a UART TX.

Parameters:
- FAS0, 8'hF6, first alignment byte.
- FAS1, 8'h28, second alignment byte.
- PYLD_LEN, 16, payload bytes per frame (legal range 1..255).
- ACK_BYTE, 8'hAA, response sent on CRC pass.
- NAK_BYTE, 8'h55, response sent on CRC fail.

Ports:
- i_clk  in  1  single clock; all logic on posedge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_line_data  in  8  line byte from line RX FIFO.
- i_line_data_valid  in  1  line byte valid.
- o_line_data_ready  out  1  line byte accepted when valid && ready.
- o_pyld_data  out  8  payload byte to client TX FIFO.
- o_pyld_data_valid  out  1  payload byte valid.
- i_pyld_data_ready  in  1  client accepts payload byte.
- o_resp_data  out  8  ACK/NAK byte to response UART TX.
- o_resp_data_valid  out  1  response byte valid.
- i_resp_data_ready  in  1  response TX accepts.
- i_arq_en  in  1  ARQ mode (sampled at FAS1 match, held for the frame).
- o_crc_val  out  8  CRC computed over the last completed frame.
- o_good_cnt  out  8  saturating count of CRC-pass frames.
- o_bad_cnt  out  8  saturating count of CRC-fail frames.
- o_rx_state  out  3  current FSM state encoding.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - State enters HUNT.
  - All valid outputs go to 0; o_line_data_ready goes to 0 for that cycle.
  - o_crc_val, o_good_cnt and o_bad_cnt clear to 0.
  - Buffer pointers clear.
  - Reset mid-frame discards the partial frame; no response is emitted.
- State encodings: HUNT=0, FAS=1, PYLD=2, CRC=3, RESP=4, DRAIN=5.
- o_line_data_ready is 1 in HUNT, FAS, PYLD and CRC; it is 0 in RESP and DRAIN, which backpressures the line.
- HUNT: an accepted byte equal to FAS0 moves to FAS.
- FAS:
  - Accepted byte == FAS1: latch i_arq_en, clear CRC register and write pointer, go to PYLD.
  - Accepted byte == FAS0: stay in FAS.
  - Any other byte: return to HUNT.
- PYLD:
  - Each accepted byte is written to buffer[wr_ptr], and the CRC is updated.
  - CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - After byte PYLD_LEN-1, go to CRC.
- CRC (one accepted byte):
  - Compare the byte against the computed CRC; load o_crc_val with the computed CRC.
  - Pass increments o_good_cnt; fail increments o_bad_cnt. Both counters saturate at 8'hFF.
  - ARQ on: go to RESP.
  - ARQ off: go to DRAIN regardless of the result; payload is always forwarded and counters still update.
- RESP:
  - Present ACK_BYTE on pass, NAK_BYTE on fail, with o_resp_data_valid=1.
  - Data is held stable until i_resp_data_ready.
  - On the handshake: pass goes to DRAIN; fail discards the buffer and goes to HUNT.
- DRAIN:
  - Present buffer[rd_ptr] with o_pyld_data_valid=1, registered output, held stable while valid && !ready.
  - rd_ptr advances on each handshake.
  - After PYLD_LEN handshakes, go to HUNT; o_pyld_data_valid drops the cycle after the last handshake.
- Latency:
  - First payload byte is valid 1 cycle after entering DRAIN.
  - The response byte is valid 1 cycle after the CRC byte is accepted.
- i_line_data_valid may drop at any time mid-frame; the FSM waits with no timeout.
- i_arq_en changes mid-frame have no effect until the next FAS1 match.
- Buffer: PYLD_LEN x 8 register array or inferred RAM. wr_ptr and rd_ptr are 8-bit and never wrap within a frame.

Test Plan:
- PYLD_LEN=9, ARQ on. Send F6 28, "123456789" (31..39), F4.
  - Expect o_crc_val=F4, o_good_cnt=1, o_resp_data=AA.
  - Expect client to receive 31..39 in order.
- Same frame with CRC byte 00.
  - Expect NAK 55 and o_bad_cnt=1.
  - Expect no o_pyld_data_valid pulse; state returns to 0.
- Same frame with CRC byte 00, ARQ off.
  - Expect no response byte and o_bad_cnt=1.
  - Expect all 9 payload bytes forwarded.
- Alignment: send 00 F6 F6 28 followed by a valid all-zero 9-byte payload with CRC 00.
  - Expect lock on the second F6 and ACK AA.
  - Send F6 11: expect return to HUNT with no counter change.
- Backpressure: hold i_pyld_data_ready=0 for 5 cycles mid-DRAIN and i_resp_data_ready=0 for 3 cycles in RESP.
  - Expect data stable and o_line_data_ready=0 throughout.
  - Expect no bytes lost or duplicated.
- Pull i_rst_n low during PYLD (byte 4) and after 256 good frames.
  - Expect all outputs at reset values and counters 0.
  - Before reset, o_good_cnt is saturated at FF.
